// File: rtl/instruction_sequencer.sv
// instruction_sequencer: opcode-driven datapath sequencer.
// FSM IDLE/CLEAR/EXEC/WB issues registered Clear/Enable strobes, source
// and ALU selects, and counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN -- an accepted illegal opcode
// locks the sequencer (Busy=1, InstrReady=0, Illegal=1) until reset.
module instruction_sequencer #(
  parameter int unsigned OPW        = 4,
  parameter int unsigned SELW       = 3,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned CNTW       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  instruction,
  input  logic            InstrValid,
  output logic            InstrReady,
  output logic            Clear,
  output logic            EnableA,
  output logic            EnableB,
  output logic            EnableOut,
  output logic            BSel,
  output logic [SELW-1:0] AluSel,
  output logic            Busy,
  output logic            Illegal,
  output logic [CNTW-1:0] RetireCount
);

  if (2**OPW < 4 + 2**SELW) begin : g_bad_opw
    $error("instruction_sequencer: opcode space too small for ALU select range");
  end
  if (CLR_CYCLES < 1 || CLR_CYCLES > 15) begin : g_bad_clr
    $error("instruction_sequencer: CLR_CYCLES must be 1..15");
  end

  localparam int unsigned ALU_LAST = 4 + 2**SELW - 1;
  localparam logic [3:0]  CNT_LAST = 4'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, EXEC, WB} state_t;
  typedef enum logic [1:0] {K_LDA, K_LDB, K_ALU, K_ILL} kind_t;

  state_t          state, state_d;
  kind_t           kind, kind_d;
  logic [3:0]      clr_cnt, cnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            bsel_q, bsel_d;
  logic            final_cycle, accept, retire;
  logic            is_clr, is_lda, is_ldb, is_alu;
  logic [31:0]     op_u;

  // Opcode decode of the presented instruction
  always_comb begin
    op_u   = 32'(instruction);
    is_clr = (op_u == 32'd0);
    is_lda = (op_u == 32'd1);
    is_ldb = (op_u == 32'd2) || (op_u == 32'd3);
    is_alu = (op_u >= 32'd4) && (op_u <= ALU_LAST);
  end

  // Next-state, handshake and retire decisions
  always_comb begin
    final_cycle = 1'b0;
    case (state)
      CLEAR:   final_cycle = (clr_cnt == CNT_LAST);
      EXEC: begin
        final_cycle = (kind != K_ALU);
`ifdef ILLEGAL_TRAP_EN
        if (kind == K_ILL) final_cycle = 1'b0;
`endif
      end
      WB:      final_cycle = 1'b1;
      default: final_cycle = 1'b0;
    endcase
    InstrReady = (state == IDLE) || final_cycle;
    accept     = InstrValid && InstrReady;
    // An illegal opcode completes without counting as retired
    retire     = final_cycle && !(state == EXEC && kind == K_ILL);

    state_d = state;
    kind_d  = kind;
    cnt_d   = clr_cnt;
    sel_d   = sel_q;
    bsel_d  = bsel_q;
    if (accept) begin
      sel_d  = '0;
      bsel_d = 1'b0;
      cnt_d  = '0;
      if (is_clr) begin
        state_d = CLEAR;
        kind_d  = K_LDA;
      end else if (is_lda) begin
        state_d = EXEC;
        kind_d  = K_LDA;
      end else if (is_ldb) begin
        state_d = EXEC;
        kind_d  = K_LDB;
        bsel_d  = instruction[0];
      end else if (is_alu) begin
        state_d = EXEC;
        kind_d  = K_ALU;
        sel_d   = SELW'(op_u - 32'd4);
      end else begin
        state_d = EXEC;
        kind_d  = K_ILL;
      end
    end else if (final_cycle) begin
      state_d = IDLE;
      sel_d   = '0;
      bsel_d  = 1'b0;
    end else begin
      case (state)
        CLEAR:   cnt_d = clr_cnt + 4'd1;
        EXEC:    if (kind == K_ALU) state_d = WB;
        default: state_d = state;
      endcase
    end
  end

  // State, select and counter registers; strobes registered from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      kind        <= K_LDA;
      clr_cnt     <= '0;
      sel_q       <= '0;
      bsel_q      <= 1'b0;
      Clear       <= 1'b0;
      EnableA     <= 1'b0;
      EnableB     <= 1'b0;
      EnableOut   <= 1'b0;
      BSel        <= 1'b0;
      AluSel      <= '0;
      Busy        <= 1'b0;
      RetireCount <= '0;
    end else begin
      state       <= state_d;
      kind        <= kind_d;
      clr_cnt     <= cnt_d;
      sel_q       <= sel_d;
      bsel_q      <= bsel_d;
      Clear       <= (state_d == CLEAR);
      EnableA     <= (state_d == CLEAR) || (state_d == EXEC && kind_d == K_LDA);
      EnableB     <= (state_d == CLEAR) || (state_d == EXEC && kind_d == K_LDB);
      EnableOut   <= (state_d == CLEAR) || (state_d == WB);
      BSel        <= (state_d == EXEC) && (kind_d == K_LDB) && bsel_d;
      AluSel      <= ((state_d == EXEC || state_d == WB) && kind_d == K_ALU) ? sel_d : '0;
      Busy        <= (state_d != IDLE);
      if (retire) RetireCount <= RetireCount + CNTW'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal flag: set by an accepted illegal opcode, cleared by CLR
  always_ff @(posedge clk) begin
    if (reset) begin
      Illegal <= 1'b0;
    end else if (accept) begin
      if (is_clr) Illegal <= 1'b0;
      else if (!(is_lda || is_ldb || is_alu)) Illegal <= 1'b1;
    end
  end
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer (default parameters).
// Driver pushes the expected post-edge output vector per cycle; monitor
// pops and compares shortly after each rising edge.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  instruction = '0;
  logic        InstrValid = 1'b0;
  logic        InstrReady, Clear, EnableA, EnableB, EnableOut, BSel, Busy, Illegal;
  logic [2:0]  AluSel;
  logic [15:0] RetireCount;

  typedef struct packed {
    logic        rdy, busy, ill, clr, ea, eb, eo, bsel;
    logic [2:0]  alu;
    logic [15:0] ret;
  } obs_t;

  obs_t  q[$];
  string names[$];
  obs_t  act;
  int    checks = 0;
  int    errors = 0;

  instruction_sequencer #(.OPW(4), .SELW(3), .CLR_CYCLES(2), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Clear(Clear), .EnableA(EnableA), .EnableB(EnableB),
    .EnableOut(EnableOut), .BSel(BSel), .AluSel(AluSel), .Busy(Busy),
    .Illegal(Illegal), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  assign act = {InstrReady, Busy, Illegal, Clear, EnableA, EnableB, EnableOut, BSel,
                AluSel, RetireCount};

  function automatic obs_t E(logic rdy, logic busy, logic ill, logic clr, logic ea,
                             logic eb, logic eo, logic bsel, logic [2:0] alu,
                             logic [15:0] ret);
    return {rdy, busy, ill, clr, ea, eb, eo, bsel, alu, ret};
  endfunction

  function automatic obs_t IDL(logic [15:0] ret);
    return E(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, ret);
  endfunction

  // Monitor: compare the observed outputs against the next scoreboard entry
  always @(posedge clk) begin
    #2;
    if (q.size() != 0) begin
      obs_t  e;
      string nm;
      e  = q.pop_front();
      nm = names.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (rdy busy ill clr ea eb eo bsel alu ret)",
                 nm, act, e);
      end
    end
  end

  task automatic step(input logic rst, input logic v, input logic [3:0] op,
                      input obs_t e, input string nm);
    @(negedge clk);
    reset       = rst;
    InstrValid  = v;
    instruction = op;
    q.push_back(e);
    names.push_back(nm);
    @(posedge clk);
  endtask

  initial begin
    step(1, 0, 0, IDL(0), "reset_a");
    step(1, 0, 0, IDL(0), "reset_b");
    step(0, 0, 0, IDL(0), "post_reset");

    // CLR: two cycles of all strobes, then one retire
    step(0, 1, 0, E(0, 1, 0, 1, 1, 1, 1, 0, 0, 0), "clr_c1");
    step(0, 0, 0, E(1, 1, 0, 1, 1, 1, 1, 0, 0, 0), "clr_c2");
    step(0, 0, 0, IDL(1), "clr_done");

    // Back-to-back 1, 3, 9 with valid held high
    step(0, 1, 1, E(1, 1, 0, 0, 1, 0, 0, 0, 0, 1), "b2b_lda");
    step(0, 1, 3, E(1, 1, 0, 0, 0, 1, 0, 1, 0, 2), "b2b_ldb1");
    step(0, 1, 9, E(0, 1, 0, 0, 0, 0, 0, 0, 5, 3), "b2b_alu5_exec");
    step(0, 1, 9, E(1, 1, 0, 0, 0, 0, 1, 0, 5, 3), "b2b_alu5_wb");
    step(0, 0, 0, IDL(4), "b2b_done");

    // LDB BSel=0, ALU range boundaries 4 and 11
    step(0, 1, 2,  E(1, 1, 0, 0, 0, 1, 0, 0, 0, 4), "ldb0");
    step(0, 1, 4,  E(0, 1, 0, 0, 0, 0, 0, 0, 0, 5), "alu0_exec");
    step(0, 1, 11, E(1, 1, 0, 0, 0, 0, 1, 0, 0, 5), "alu0_wb");
    step(0, 1, 11, E(0, 1, 0, 0, 0, 0, 0, 0, 7, 6), "alu7_exec");
    step(0, 0, 0,  E(1, 1, 0, 0, 0, 0, 1, 0, 7, 6), "alu7_wb");
    step(0, 0, 0,  IDL(7), "alu_done");

    // CLR then LDA accepted in the last CLEAR cycle
    step(0, 1, 0, E(0, 1, 0, 1, 1, 1, 1, 0, 0, 7), "clr_lda_c1");
    step(0, 1, 1, E(1, 1, 0, 1, 1, 1, 1, 0, 0, 7), "clr_lda_c2");
    step(0, 1, 1, E(1, 1, 0, 0, 1, 0, 0, 0, 0, 8), "clr_lda_exec");
    step(0, 0, 0, IDL(9), "clr_lda_done");

    // Illegal opcodes (12 is first past the ALU range)
`ifdef ILLEGAL_TRAP_EN
    step(0, 1, 12, E(0, 1, 1, 0, 0, 0, 0, 0, 0, 9), "trap_enter");
    for (int i = 0; i < 10; i++)
      step(0, 1, 1, E(0, 1, 1, 0, 0, 0, 0, 0, 0, 9), "trap_hold");
    step(1, 0, 0, IDL(0), "trap_reset");
`else
    step(0, 1, 12, E(1, 1, 0, 0, 0, 0, 0, 0, 0, 9), "ill12");
    step(0, 1, 15, E(1, 1, 0, 0, 0, 0, 0, 0, 0, 9), "ill15");
    step(0, 0, 0,  IDL(9), "ill_done");
    step(1, 0, 0,  IDL(0), "ill_reset");
`endif
    step(0, 0, 0, IDL(0), "post_reset2");

    // Reset during ALU EXEC aborts without WB or retire
    step(0, 1, 11, E(0, 1, 0, 0, 0, 0, 0, 0, 7, 0), "abort_exec");
    step(1, 1, 11, IDL(0), "abort_reset");
    step(0, 0, 0,  IDL(0), "abort_after1");
    step(0, 0, 0,  IDL(0), "abort_after2");

    // Reset during a partial CLEAR
    step(0, 1, 0, E(0, 1, 0, 1, 1, 1, 1, 0, 0, 0), "abort_clr");
    step(1, 0, 0, IDL(0), "abort_clr_reset");
    step(0, 0, 0, IDL(0), "abort_clr_after");

    // Retire counter wrap: 65536 back-to-back LDAs
    for (int i = 0; i < 65536; i++)
      step(0, 1, 1, E(1, 1, 0, 0, 1, 0, 0, 0, 0, 16'(i)), "wrap_lda");
    step(0, 0, 0, IDL(0), "wrap_done");

    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
